// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one-outstanding imem reads and feeds IF/ID.
// Optional IF_PERF_CNT_EN adds fetch_count / bubble_count performance counters.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_4,
  output logic [31:0] Instrucction,
  output logic        IF_ID_enable
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count
`endif
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic [31:0] pc_inc;
  logic [31:0] redirect_tgt;
  logic [31:0] hold_buf;
  logic        capture;
  logic        present;
  logic [31:0] present_word;

  function automatic logic [31:0] pc_plus4(input logic [31:0] value);
    return value + 32'd4;
  endfunction

  assign pc_inc       = pc_plus4(pc);
  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
  assign imem_addr    = pc;
  assign imem_req     = (state == S_REQ) && !redirect_valid;

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    capture      = 1'b0;
    present      = 1'b0;
    present_word = imem_rdata;
    case (state)
      S_REQ: begin
        if (redirect_valid) begin
          pc_nxt = redirect_tgt;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // A redirect kills the in-flight fetch; if data has not come back yet it must be drained.
        if (redirect_valid) begin
          pc_nxt    = redirect_tgt;
          state_nxt = imem_valid ? S_REQ : S_DRAIN;
        end else if (imem_valid) begin
          if (stall) begin
            capture   = 1'b1;
            state_nxt = S_HOLD;
          end else begin
            present   = 1'b1;
            pc_nxt    = pc_inc;
            state_nxt = S_REQ;
          end
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_nxt    = redirect_tgt;
          state_nxt = S_REQ;
        end else if (!stall) begin
          present      = 1'b1;
          present_word = hold_buf;
          pc_nxt       = pc_inc;
          state_nxt    = S_REQ;
        end
      end
      S_DRAIN: begin
        if (redirect_valid) begin
          pc_nxt = redirect_tgt;
        end
        if (imem_valid) begin
          state_nxt = S_REQ;
        end
      end
      default: begin
        state_nxt = S_REQ;
      end
    endcase
  end

  // Control and presented outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_REQ;
      pc           <= RESET_PC;
      PC_4         <= 32'h0000_0000;
      Instrucction <= 32'h0000_0000;
      IF_ID_enable <= 1'b1;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      IF_ID_enable <= !present;
      if (present) begin
        Instrucction <= present_word;
        PC_4         <= pc_inc;
      end
    end
  end

  // Stalled-response buffer: pure data, only meaningful while in S_HOLD
  always_ff @(posedge clk) begin
    if (capture) begin
      hold_buf <= imem_rdata;
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_count  <= 32'h0000_0000;
      bubble_count <= 32'h0000_0000;
    end else begin
      if (present) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (IF_ID_enable) begin
        bubble_count <= bubble_count + 32'd1;
      end
    end
  end
`endif

endmodule
